// File: rtl/bids22_cmdseq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bids22_cmdseq_pkg                                               |
// | Purpose  : Shared definitions for the bids22 host command sequencer:       |
// |            controller opcodes and error codes (bids22defs), the local      |
// |            START_ROUND / CLRERR opcodes, the local error codes and the     |
// |            sequencer state enum.                                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package bids22_cmdseq_pkg;

  // Controller opcodes (bids22defs)
  localparam logic [3:0] NO_OP        = 4'h0;
  localparam logic [3:0] UNLOCK       = 4'h1;
  localparam logic [3:0] LOCK         = 4'h2;
  localparam logic [3:0] LOADX        = 4'h3;
  localparam logic [3:0] LOADY        = 4'h4;
  localparam logic [3:0] LOADZ        = 4'h5;
  localparam logic [3:0] SETXVALUE    = 4'h6;
  localparam logic [3:0] SETYVALUE    = 4'h7;
  localparam logic [3:0] SETBIDCHARGE = 4'h8;

  // Sequencer-local opcodes, never forwarded to the controller
  localparam logic [3:0] CLRERR       = 4'hE;
  localparam logic [3:0] START_ROUND  = 4'hF;

  // Controller error codes (bids22defs)
  localparam logic [3:0] NOERROR         = 4'h0;
  localparam logic [3:0] BADKEY          = 4'h1;
  localparam logic [3:0] ALREADYUNLOCKED = 4'h2;
  localparam logic [3:0] CANNOTASSIGN    = 4'h3;

  // Sequencer-local error codes reported on last_err
  localparam logic [3:0] LOCAL_BADOP_ERR   = 4'hE;
  localparam logic [3:0] LOCAL_TIMEOUT_ERR = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAITRDY  = 3'd2,
    S_ROUND    = 3'd3,
    S_WAITOVER = 3'd4
  } cmdseq_state_t;

  // True for opcodes the controller itself understands
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op <= SETBIDCHARGE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bids22_cmdseq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bids22_cmdseq_if                                                |
// | Purpose  : Host command push interface (valid/ready handshake).            |
// | Signals  : host_valid, host_op[3:0], host_data[DATAWIDTH-1:0] (host->seq), |
// |            host_ready (seq->host).                                         |
// |            master = host side, slave = sequencer side.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface bids22_cmdseq_if #(
  parameter int DATAWIDTH = 32
) ();
  logic                 host_valid;
  logic                 host_ready;
  logic [3:0]           host_op;
  logic [DATAWIDTH-1:0] host_data;

  modport master (output host_valid, output host_op, output host_data, input  host_ready);
  modport slave  (input  host_valid, input  host_op, input  host_data, output host_ready);
endinterface
`default_nettype wire

// File: rtl/bids22_cmdfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bids22_cmdfifo                                                  |
// | Purpose  : Synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.   |
// |            Read data is the current head (show-ahead).                     |
// | Ports    : clk, reset_n (async active-low), push/wdata, pop/rdata,         |
// |            full, empty, count.                                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bids22_cmdfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           wdata,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO refuses a push even when a pop frees a slot this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/bids22_cmdseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bids22_cmdseq                                                   |
// | Purpose  : Host-side command sequencer for the bids22 auction controller.  |
// |            Replays queued config opcodes one per issue slot, checks err,   |
// |            and expands START_ROUND into a ready-gated C_start pulse.       |
// | Ports    : clk, reset_n (async active-low); host (cmd push interface);    |
// |            C_op/C_data/C_start (registered, to controller); ready, err,    |
// |            roundOver (from controller); busy, seq_err, last_err,           |
// |            rounds_done (status).                                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bids22_cmdseq
  import bids22_cmdseq_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int DEPTH      = 4,
  parameter int RDYTIMEOUT = 255
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  bids22_cmdseq_if.slave            host,
  output logic      [3:0]           C_op,
  output logic      [DATAWIDTH-1:0] C_data,
  output logic                      C_start,
  input  wire logic                 ready,
  input  wire logic [3:0]           err,
  input  wire logic                 roundOver,
  output logic                      busy,
  output logic                      seq_err,
  output logic      [3:0]           last_err,
  output logic      [7:0]           rounds_done
);
  localparam int WCW = $clog2(RDYTIMEOUT + 1);

  cmdseq_state_t          state_q, state_d;
  logic [3:0]             c_op_q, c_op_d;
  logic [DATAWIDTH-1:0]   c_data_q, c_data_d;
  logic                   c_start_q, c_start_d;
  logic [15:0]            round_cnt_q, round_cnt_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                   seq_err_q, seq_err_d;
  logic [3:0]             last_err_q, last_err_d;
  logic [7:0]             rounds_done_q, rounds_done_d;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [DATAWIDTH+3:0]   fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [3:0]             head_op;
  logic [DATAWIDTH-1:0]   head_data;

  bids22_cmdfifo #(.DEPTH(DEPTH), .WIDTH(DATAWIDTH + 4)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (host.host_valid),
    .wdata   ({host.host_op, host.host_data}),
    .pop     (fifo_pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_op   = fifo_head[DATAWIDTH+3:DATAWIDTH];
  assign head_data = fifo_head[DATAWIDTH-1:0];

  // The controller-facing outputs are computed for the state being entered,
  // so a registered C_op lines up exactly with the ISSUE cycle.
  always_comb begin
    state_d       = state_q;
    c_op_d        = NO_OP;
    c_data_d      = '0;
    c_start_d     = 1'b0;
    round_cnt_d   = round_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    seq_err_d     = seq_err_q;
    last_err_d    = last_err_q;
    rounds_done_d = rounds_done_q;
    fifo_pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_op == START_ROUND) begin
            state_d     = S_WAITRDY;
            wait_cnt_d  = '0;
            round_cnt_d = (head_data[15:0] == 16'd0) ? 16'd1 : head_data[15:0];
          end else if (head_op == CLRERR) begin
            seq_err_d  = 1'b0;
            last_err_d = NOERROR;
          end else if (is_ctrl_op(head_op)) begin
            state_d  = S_ISSUE;
            c_op_d   = head_op;
            c_data_d = head_data;
          end else begin
            seq_err_d  = 1'b1;
            last_err_d = LOCAL_BADOP_ERR;
          end
        end
      end

      S_ISSUE: begin
        // err is valid in the same cycle the opcode is presented
        if (err != NOERROR) begin
          seq_err_d  = 1'b1;
          last_err_d = err;
        end
        state_d = S_IDLE;
      end

      S_WAITRDY: begin
        if (ready) begin
          state_d   = S_ROUND;
          c_start_d = 1'b1;
        end else if (wait_cnt_q == WCW'(RDYTIMEOUT - 1)) begin
          state_d    = S_IDLE;
          seq_err_d  = 1'b1;
          last_err_d = LOCAL_TIMEOUT_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_ROUND: begin
        // round_cnt holds the remaining C_start cycles including the current one
        if (round_cnt_q == 16'd1) begin
          state_d = S_WAITOVER;
        end else begin
          round_cnt_d = round_cnt_q - 16'd1;
          c_start_d   = 1'b1;
        end
      end

      S_WAITOVER: begin
        if (roundOver) begin
          rounds_done_d = rounds_done_q + 8'd1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      c_op_q        <= NO_OP;
      c_data_q      <= '0;
      c_start_q     <= 1'b0;
      round_cnt_q   <= 16'd0;
      wait_cnt_q    <= '0;
      seq_err_q     <= 1'b0;
      last_err_q    <= NOERROR;
      rounds_done_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      c_op_q        <= c_op_d;
      c_data_q      <= c_data_d;
      c_start_q     <= c_start_d;
      round_cnt_q   <= round_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      seq_err_q     <= seq_err_d;
      last_err_q    <= last_err_d;
      rounds_done_q <= rounds_done_d;
    end
  end

  assign host.host_ready = ~fifo_full;
  assign C_op            = c_op_q;
  assign C_data          = c_data_q;
  assign C_start         = c_start_q;
  assign busy            = (fifo_count != '0) || (state_q != S_IDLE);
  assign seq_err         = seq_err_q;
  assign last_err        = last_err_q;
  assign rounds_done     = rounds_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bids22_cmdseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bids22_cmdseq                                                |
// | Purpose  : Self-checking bench for bids22_cmdseq: table of single config   |
// |            commands plus hand-written multi-cycle sequences (back-to-back |
// |            issue, rounds, ready timeout, FIFO full, reset mid-round).      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bids22_cmdseq;
  import bids22_cmdseq_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int RDYTO = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          ready;
  logic [3:0]    err;
  logic          roundOver;
  logic          busy;
  logic          seq_err;
  logic [3:0]    last_err;
  logic [7:0]    rounds_done;

  int n_vec = 0;
  int n_bad = 0;

  bids22_cmdseq_if #(.DATAWIDTH(DW)) hif ();

  bids22_cmdseq #(.DATAWIDTH(DW), .DEPTH(DEPTH), .RDYTIMEOUT(RDYTO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .host        (hif.slave),
    .C_op        (C_op),
    .C_data      (C_data),
    .C_start     (C_start),
    .ready       (ready),
    .err         (err),
    .roundOver   (roundOver),
    .busy        (busy),
    .seq_err     (seq_err),
    .last_err    (last_err),
    .rounds_done (rounds_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] data;
    logic [3:0]    err_in;
    logic [3:0]    exp_op;
    logic [DW-1:0] exp_data;
    logic          exp_seq_err;
    logic [3:0]    exp_last_err;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One-cycle push; caller is positioned just after a rising edge
  task automatic push_cmd(input logic [3:0] op, input logic [DW-1:0] data);
    hif.host_valid = 1'b1;
    hif.host_op    = op;
    hif.host_data  = data;
    tick();
    hif.host_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]    got_op   [8];
    logic [DW-1:0] got_data [8];
    int            nseen;
    int            hi;
    int            lowbad;

    vecs[0] = '{SETBIDCHARGE, 32'd5,          NOERROR,         SETBIDCHARGE, 32'd5,          1'b0, NOERROR};
    vecs[1] = '{LOADX,        32'd100,        NOERROR,         LOADX,        32'd100,        1'b0, NOERROR};
    vecs[2] = '{UNLOCK,       32'h0000_0042,  ALREADYUNLOCKED, UNLOCK,       32'h0000_0042,  1'b1, ALREADYUNLOCKED};
    vecs[3] = '{CLRERR,       32'd0,          NOERROR,         NO_OP,        32'd0,          1'b0, NOERROR};
    vecs[4] = '{LOCK,         32'd7,          BADKEY,          LOCK,         32'd7,          1'b1, BADKEY};
    vecs[5] = '{LOADY,        32'hDEAD_BEEF,  NOERROR,         LOADY,        32'hDEAD_BEEF,  1'b1, BADKEY};
    vecs[6] = '{4'hA,         32'd1,          NOERROR,         NO_OP,        32'd0,          1'b1, LOCAL_BADOP_ERR};
    vecs[7] = '{CLRERR,       32'd0,          NOERROR,         NO_OP,        32'd0,          1'b0, NOERROR};
    vecs[8] = '{SETXVALUE,    32'h1234_5678,  NOERROR,         SETXVALUE,    32'h1234_5678,  1'b0, NOERROR};

    reset_n        = 1'b0;
    hif.host_valid = 1'b0;
    hif.host_op    = 4'h0;
    hif.host_data  = '0;
    ready          = 1'b0;
    err            = 4'h0;
    roundOver      = 1'b0;

    // Reset state, checked before any clock edge
    #3;
    chk("rst_c_op",        32'(C_op),        32'h0);
    chk("rst_c_data",      C_data,           32'h0);
    chk("rst_c_start",     32'(C_start),     32'h0);
    chk("rst_host_ready",  32'(hif.host_ready), 32'h1);
    chk("rst_busy",        32'(busy),        32'h0);
    chk("rst_seq_err",     32'(seq_err),     32'h0);
    chk("rst_last_err",    32'(last_err),    32'h0);
    chk("rst_rounds_done", 32'(rounds_done), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Single commands: push at edge t, issue cycle after edge t+1, err sampled there
    for (int i = 0; i < 9; i++) begin
      push_cmd(vecs[i].op, vecs[i].data);
      tick();
      chk($sformatf("v%0d_c_op", i),   32'(C_op), 32'(vecs[i].exp_op));
      chk($sformatf("v%0d_c_data", i), C_data,    vecs[i].exp_data);
      err = vecs[i].err_in;
      tick();
      err = NOERROR;
      chk($sformatf("v%0d_seq_err", i),  32'(seq_err),  32'(vecs[i].exp_seq_err));
      chk($sformatf("v%0d_last_err", i), 32'(last_err), 32'(vecs[i].exp_last_err));
      chk($sformatf("v%0d_idle_op", i),  32'(C_op),     32'(NO_OP));
    end

    // Back-to-back config commands issue two cycles apart
    hif.host_valid = 1'b1;
    hif.host_op    = SETBIDCHARGE;
    hif.host_data  = 32'd5;
    tick();
    hif.host_op    = LOADX;
    hif.host_data  = 32'd100;
    tick();
    hif.host_valid = 1'b0;
    chk("b2b_first_op",   32'(C_op), 32'(SETBIDCHARGE));
    chk("b2b_first_data", C_data,    32'd5);
    tick();
    chk("b2b_gap_op",     32'(C_op), 32'(NO_OP));
    tick();
    chk("b2b_second_op",   32'(C_op), 32'(LOADX));
    chk("b2b_second_data", C_data,    32'd100);
    tick();
    chk("b2b_seq_err", 32'(seq_err), 32'h0);

    // START_ROUND/3: ready low 10 cycles, then high; roundOver in ROUND ignored
    push_cmd(START_ROUND, 32'd3);
    lowbad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (C_start) lowbad++;
    end
    chk("rnd_no_start_before_ready", 32'(lowbad), 32'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rnd_start_rise", 32'(C_start), 32'h1);
    hi = 1;
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!C_start) break;
      hi++;
      tick();
    end
    chk("rnd_start_len", 32'(hi), 32'd3);
    chk("rnd_ignored_over", 32'(rounds_done), 32'd0);
    chk("rnd_busy_waitover", 32'(busy), 32'h1);
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    chk("rnd_rounds_done", 32'(rounds_done), 32'd1);
    chk("rnd_busy_done",   32'(busy),        32'h0);

    // Ready timeout: RDYTO cycles in WAITRDY, then error and drop
    push_cmd(START_ROUND, 32'd2);
    lowbad = 0;
    for (int k = 0; k < RDYTO; k++) begin
      tick();
      if (C_start) lowbad++;
    end
    chk("to_seq_err_early", 32'(seq_err), 32'h0);
    tick();
    if (C_start) lowbad++;
    chk("to_seq_err",   32'(seq_err),  32'h1);
    chk("to_last_err",  32'(last_err), 32'(LOCAL_TIMEOUT_ERR));
    chk("to_busy",      32'(busy),     32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (C_start) lowbad++;
    end
    chk("to_no_start",  32'(lowbad),   32'h0);
    push_cmd(CLRERR, 32'd0);
    tick();
    chk("to_clrerr", 32'({seq_err, last_err}), 32'h0);

    // FIFO fill while waiting for roundOver
    ready = 1'b1;
    push_cmd(START_ROUND, 32'd1);
    repeat (3) tick();
    ready = 1'b0;
    hif.host_valid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      hif.host_op   = LOADX + 4'(i);
      hif.host_data = 32'(i + 1);
      chk($sformatf("fill_ready_%0d", i), 32'(hif.host_ready), (i < DEPTH) ? 32'h1 : 32'h0);
      tick();
    end
    hif.host_valid = 1'b0;
    chk("fill_c_op_held", 32'(C_op), 32'(NO_OP));
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    nseen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (C_op != NO_OP && nseen < 8) begin
        got_op[nseen]   = C_op;
        got_data[nseen] = C_data;
        nseen++;
      end
    end
    chk("fill_drain_count", 32'(nseen), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i < nseen) begin
        chk($sformatf("fill_drain_op_%0d", i),   32'(got_op[i]), 32'(LOADX + 4'(i)));
        chk($sformatf("fill_drain_data_%0d", i), got_data[i],    32'(i + 1));
      end
    end
    chk("fill_rounds_done", 32'(rounds_done), 32'd2);

    // Reset asserted mid-ROUND with commands queued
    ready = 1'b1;
    push_cmd(START_ROUND, 32'd5);
    tick();
    tick();
    ready = 1'b0;
    chk("rst_mid_start_on", 32'(C_start), 32'h1);
    push_cmd(LOADX, 32'd9);
    push_cmd(LOADY, 32'd8);
    chk("rst_mid_busy_before", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_c_start",     32'(C_start),     32'h0);
    chk("rst_mid_busy",        32'(busy),        32'h0);
    chk("rst_mid_rounds_done", 32'(rounds_done), 32'd0);
    chk("rst_mid_host_ready",  32'(hif.host_ready), 32'h1);
    tick();
    reset_n = 1'b1;
    lowbad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (C_op != NO_OP || C_start) lowbad++;
    end
    chk("rst_mid_fifo_discarded", 32'(lowbad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
